if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the PC register, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register.
- Honours stall requests from the hazard unit and redirect requests (taken branch or jump) resolved downstream.
- Feeds the decode stage directly; also keeps fetch/bubble performance counters.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hazard-unit stall; hold PC and IF/ID.
- redirect_i  in  1  taken branch or jump; load redirect_pc_i and flush IF/ID.
- redirect_pc_i  in  ADDR_W  redirect target.
- imem_addr_o  out  ADDR_W  instruction memory address (combinational read).
- imem_rdata_i  in  INSTR_W  instruction word at imem_addr_o, valid same cycle.
- id_instr_o  out  INSTR_W  IF/ID instruction.
- id_pc_o  out  ADDR_W  IF/ID PC of that instruction.
- id_pc4_o  out  ADDR_W  IF/ID PC+4.
- id_valid_o  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_cnt_o  out  CNT_W  count of valid instructions loaded into IF/ID.
- bubble_cnt_o  out  CNT_W  count of flush bubbles inserted.

Behaviour:
- Reset is asynchronous and active-high on rst; single clock clk. All state is cleared on rst assertion regardless of clk:
  - pc = RESET_PC
  - id_instr_o = NOP (32'h0000_0000), id_pc_o = 0, id_pc4_o = 0, id_valid_o = 0
  - both counters = 0
- imem_addr_o = pc, combinational. The first fetch address after reset release is RESET_PC.
- Latency: the instruction at pc appears on id_* one rising edge after it is addressed.
- Per rising edge, priority is redirect > stall > advance:
  - redirect_i=1 (stall_i ignored): pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}; IF/ID <= bubble (NOP, pc/pc4 = 0, valid = 0); bubble_cnt++.
  - redirect_i=0, stall_i=1: pc and all IF/ID fields hold; counters hold.
  - Otherwise: pc <= pc+4; IF/ID <= {imem_rdata_i, pc, pc+4}, valid = 1; fetch_cnt++.
- Alignment: redirect targets are force-aligned (bits [1:0] cleared). pc[1:0] is always 0.
- Arithmetic:
  - pc+4 is modulo 2^ADDR_W; pc = 32'hFFFF_FFFC advances to 0, and id_pc4_o reports 0.
  - Counters wrap modulo 2^CNT_W with no saturation.
- Consecutive redirects: each loads the new target and inserts one bubble each.
- Sustained stall: holds indefinitely with no side effects.
- Reset mid-operation: immediate return to reset state. The first post-reset fetch is RESET_PC with no residual bubble or redirect state.
- X handling: imem_rdata_i is sampled only when advancing. X on it during stall or redirect must not propagate into IF/ID.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP_INSTR = 32'h0000_0000
  - RESET_PC default
  - INSTR_BYTES = 4
  - an if_id_t struct {instr, pc, pc4, valid}, reused by the ID stage
- One natural sub-module: pc_reg, containing:
  - PC flop with async reset
  - redirect/stall/advance next-PC mux
  - alignment masking
- IF/ID register and counters stay in if_stage.

Test Plan:
- Reset, then 4 cycles free-running with memory word = address: imem_addr 3000, 3004, 3008, 300C; id_instr lags by 1 cycle; id_pc4 = id_pc+4; id_valid=1 from the 2nd edge; fetch_cnt=4.
- stall_i=1 for 3 cycles at pc=3008: imem_addr stays 3008; id_* frozen at 3004; fetch_cnt unchanged; resumes at 300C.
- redirect_i=1, redirect_pc_i=3043: next pc=3040; id_valid=0, id_instr=0; bubble_cnt=1; the following cycle id_pc=3040.
- redirect_i and stall_i both 1: redirect wins; pc = target; bubble inserted; counters as redirect case.
- Force pc to FFFF_FFFC via redirect, advance: pc=0; id_pc4_o=0; id_pc=FFFF_FFFC.
- Assert rst asynchronously mid-cycle during a stall: outputs clear immediately without a clock edge; after release the first fetch address is 3000 with id_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used across the pipeline stages.
//   NOP_INSTR          : encoding that a flushed pipeline slot carries
//   RESET_PC_DEFAULT   : default fetch address out of reset
//   INSTR_BYTES        : size of one instruction, i.e. the PC stride
//   if_id_t            : IF/ID pipeline register contents, consumed by ID
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC selection.
//   clk, rst  : clock, asynchronous active-high reset
//   stall     : hold the PC
//   redirect  : load target (word-aligned); takes priority over stall
//   target    : redirect destination
//   pc        : current fetch address
//   pc4       : pc + one instruction, modulo 2^ADDR_W
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0] pc_next;

  assign pc4 = pc + ADDR_W'(INSTR_BYTES);

  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = target & ALIGN_MASK;
    end else if (!stall) begin
      pc_next = pc4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC & ALIGN_MASK;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word into IF/ID. Priority per edge is
// redirect > stall > advance. Also counts fetched instructions and bubbles.
//   clk, rst        : clock, asynchronous active-high reset
//   stall_i         : hold PC and IF/ID
//   redirect_i      : load redirect_pc_i, flush IF/ID to a bubble
//   redirect_pc_i   : redirect target (low bits ignored)
//   imem_addr_o     : instruction memory address (= PC)
//   imem_rdata_i    : instruction at imem_addr_o, same cycle
//   id_instr_o/id_pc_o/id_pc4_o/id_valid_o : IF/ID register
//   fetch_cnt_o     : valid instructions loaded into IF/ID
//   bubble_cnt_o    : flush bubbles inserted
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0]  id_pc_o,
  output logic [ADDR_W-1:0]  id_pc4_o,
  output logic               id_valid_o,
  output logic [CNT_W-1:0]   fetch_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc4;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall_i),
    .redirect (redirect_i),
    .target   (redirect_pc_i),
    .pc       (pc),
    .pc4      (pc4)
  );

  assign imem_addr_o = pc;

  // imem_rdata_i is only looked at on the advance branch, so garbage on it
  // during a stall or redirect never reaches IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr_o   <= INSTR_W'(NOP_INSTR);
      id_pc_o      <= '0;
      id_pc4_o     <= '0;
      id_valid_o   <= 1'b0;
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (redirect_i) begin
      id_instr_o   <= INSTR_W'(NOP_INSTR);
      id_pc_o      <= '0;
      id_pc4_o     <= '0;
      id_valid_o   <= 1'b0;
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end else if (!stall_i) begin
      id_instr_o   <= imem_rdata_i;
      id_pc_o      <= pc;
      id_pc4_o     <= pc4;
      id_valid_o   <= 1'b1;
      fetch_cnt_o  <= fetch_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic        id_valid_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;

  logic [31:0] junk;

  int total;
  int bad;

  // reference state
  logic [31:0] m_pc, m_instr, m_idpc, m_pc4, m_fc, m_bc;
  logic        m_valid;

  if_stage #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0000_3000),
    .CNT_W    (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .id_pc4_o      (id_pc4_o),
    .id_valid_o    (id_valid_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .bubble_cnt_o  (bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory holds word == address; when the stage is not advancing the bus
  // carries junk, which must never be captured.
  always_comb begin
    imem_rdata_i = imem_addr_o;
    if (redirect_i || stall_i) imem_rdata_i = junk;
  end

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] bc;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = '0; m_idpc = '0; m_pc4 = '0;
    m_valid = 1'b0; m_fc = '0; m_bc = '0;
  endtask

  // Apply current inputs across one rising edge and advance the model.
  task automatic step();
    if (redirect_i) begin
      m_pc = {redirect_pc_i[31:2], 2'b00};
      m_instr = '0; m_idpc = '0; m_pc4 = '0; m_valid = 1'b0;
      m_bc = m_bc + 1;
    end else if (!stall_i) begin
      m_instr = m_pc;          // memory word equals its address
      m_idpc  = m_pc;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_fc    = m_fc + 1;
      m_pc    = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".addr"},  imem_addr_o,  m_pc);
    chk({tag, ".instr"}, id_instr_o,   m_instr);
    chk({tag, ".pc"},    id_pc_o,      m_idpc);
    chk({tag, ".pc4"},   id_pc4_o,     m_pc4);
    chk({tag, ".valid"}, 32'(id_valid_o), 32'(m_valid));
    chk({tag, ".fcnt"},  fetch_cnt_o,  m_fc);
    chk({tag, ".bcnt"},  bubble_cnt_o, m_bc);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; junk = '0;

    //               stall redir target        addr          instr         pc            pc4           v     fc     bc
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h3004,     32'h3000,     32'h3000,     32'h3004,     1'b1, 32'd1, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h3008,     32'h3004,     32'h3004,     32'h3008,     1'b1, 32'd2, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h3008,     32'h3004,     32'h3004,     32'h3008,     1'b1, 32'd2, 32'd0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h3008,     32'h3004,     32'h3004,     32'h3008,     1'b1, 32'd2, 32'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h3008,     32'h3004,     32'h3004,     32'h3008,     1'b1, 32'd2, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h300C,     32'h3008,     32'h3008,     32'h300C,     1'b1, 32'd3, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h3010,     32'h300C,     32'h300C,     32'h3010,     1'b1, 32'd4, 32'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'h3043,     32'h3040,     32'h0,        32'h0,        32'h0,        1'b0, 32'd4, 32'd1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h3044,     32'h3040,     32'h3040,     32'h3044,     1'b1, 32'd5, 32'd1};
    vecs[9]  = '{1'b1, 1'b1, 32'h5006,     32'h5004,     32'h0,        32'h0,        32'h0,        1'b0, 32'd5, 32'd2};
    vecs[10] = '{1'b0, 1'b1, 32'h7000,     32'h7000,     32'h0,        32'h0,        32'h0,        1'b0, 32'd5, 32'd3};
    vecs[11] = '{1'b1, 1'b0, 32'h0,        32'h7000,     32'h0,        32'h0,        32'h0,        1'b0, 32'd5, 32'd3};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        1'b0, 32'd5, 32'd4};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        1'b1, 32'd6, 32'd4};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h0,        32'h4,        1'b1, 32'd7, 32'd4};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("reset.addr",  imem_addr_o,  32'h3000);
    chk("reset.instr", id_instr_o,   32'h0);
    chk("reset.pc",    id_pc_o,      32'h0);
    chk("reset.pc4",   id_pc4_o,     32'h0);
    chk("reset.valid", 32'(id_valid_o), 32'h0);
    chk("reset.fcnt",  fetch_cnt_o,  32'h0);
    chk("reset.bcnt",  bubble_cnt_o, 32'h0);

    // directed table
    for (int i = 0; i < 15; i++) begin
      stall_i = vecs[i].stall;
      redirect_i = vecs[i].redirect;
      redirect_pc_i = vecs[i].target;
      junk = $urandom;
      step();
      chk($sformatf("vec%0d.addr", i),  imem_addr_o,  vecs[i].addr);
      chk($sformatf("vec%0d.instr", i), id_instr_o,   vecs[i].instr);
      chk($sformatf("vec%0d.pc", i),    id_pc_o,      vecs[i].pc);
      chk($sformatf("vec%0d.pc4", i),   id_pc4_o,     vecs[i].pc4);
      chk($sformatf("vec%0d.valid", i), 32'(id_valid_o), 32'(vecs[i].valid));
      chk($sformatf("vec%0d.fcnt", i),  fetch_cnt_o,  vecs[i].fc);
      chk($sformatf("vec%0d.bcnt", i),  bubble_cnt_o, vecs[i].bc);
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      stall_i    = ($urandom_range(0, 3) == 0);
      redirect_i = ($urandom_range(0, 9) == 0);
      redirect_pc_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      junk = $urandom;
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    // sustained stall has no side effects
    stall_i = 1'b1; redirect_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      junk = $urandom;
      step();
    end
    chk_model("longstall");

    // asynchronous reset mid-cycle during a stall
    stall_i = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk_model("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall_i = 1'b0;
    #1;
    chk_model("post_rst");
    step();
    chk_model("first_fetch");
    chk("first_fetch.pc_const", id_pc_o, 32'h3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
